rc4_session_ctrl: RTL and testbench
===================================

Name: rc4_session_ctrl

Overview:
Session sequencer for the RC4 cipher core.
- On `start`: resets the core, streams the key bytes into it, and waits for `core_init_done`.
- Then fetches one keystream byte per data byte and XORs it into a byte stream for a programmed frame length.
- Sits between the host/byte-stream side and the rc4 core. It replaces ad-hoc valid wiring with a proper FSM and valid/ready handshakes.

Parameters:
- KEY_LEN, 16, key bytes loaded per session (1..256).
- FRAME_LEN_W, 16, width of frame length field.
- INIT_TIMEOUT, 1024, max cycles in WAIT_INIT before error.
- DROP_N, 256, keystream bytes discarded after init (only with RC4_DROP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  session start pulse; ignored while busy.
- frame_len  in  FRAME_LEN_W  data bytes in session; sampled on accepted start.
- key_byte  in  8  key byte.
- key_valid  in  1  key byte valid.
- key_ready  out  1  key byte accepted when key_valid&key_ready.
- in_data  in  8  ciphertext/plaintext byte.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input handshake.
- out_data  out  8  in_data XOR keystream.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts output.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at session end (normal or error).
- error  out  1  sticky; cleared on next accepted start.
- core_rst  out  1  reset to rc4 core.
- core_key  out  8  key byte to core.
- core_key_valid  out  1  one-cycle strobe per key byte.
- core_init_done  in  1  core KSA complete (level).
- core_ks_req  out  1  one-cycle keystream request.
- core_ks  in  8  keystream byte.
- core_ks_valid  in  1  keystream byte valid, ≥1 cycle after core_ks_req.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - core_rst=1.
  - All other outputs 0.
  - All counters 0.
- IDLE:
  - core_rst=1.
  - On start:
    - error cleared.
    - frame_len latched.
    - If frame_len==0: error=1, done pulse next cycle, stay IDLE.
    - Else: LOAD_KEY, with core_rst=0 from the next cycle.
- LOAD_KEY:
  - key_ready=1.
  - Each handshake registers core_key<=key_byte and core_key_valid=1 for exactly one cycle.
  - After KEY_LEN handshakes: WAIT_INIT, timeout counter=0.
- WAIT_INIT:
  - Counter increments every cycle.
  - core_init_done=1 → DROP (if enabled) else FETCH.
  - Counter reaching INIT_TIMEOUT with no init → error=1, done pulse, IDLE.
  - If init and timeout occur in the same cycle, init wins.
- FETCH:
  - core_ks_req=1 for one cycle → WAIT_KS.
  - At most one request is ever outstanding.
- WAIT_KS:
  - On core_ks_valid: ks_reg<=core_ks → XFER.
  - core_ks_valid in any state other than WAIT_KS/DROP is ignored.
- XFER:
  - in_ready = !out_valid | out_ready.
  - On in handshake:
    - out_data<=in_data^ks_reg and out_valid<=1 next cycle (latency 1).
    - Byte counter++.
    - If counter reaches frame_len → DRAIN, else → FETCH.
- Output register:
  - out_valid clears when out_ready=1 and no new load occurs in the same cycle.
  - out_data is held stable while out_valid & !out_ready.
- DRAIN:
  - When out_valid==0 (last byte taken): done pulse, IDLE.
- Throughput: max one byte per 3 cycles (FETCH, WAIT_KS ≥1, XFER).
- Counter widths:
  - Byte counter is FRAME_LEN_W bits; frame_len = 2^FRAME_LEN_W−1 is legal and has no wrap.
  - Key counter is ceil(log2(KEY_LEN+1)) bits.
- start while busy: ignored; no latch and no effect on error.

Optional Feature:
- RC4_DROP_EN defined: DROP state between WAIT_INIT and FETCH.
  - Issues DROP_N sequential single-outstanding requests.
  - Discards each returned byte.
  - in_ready=0 throughout.
  - Then enters FETCH.
- Undefined: WAIT_INIT goes directly to FETCH; DROP_N is unused and no drop logic is present.

Test Plan:
- Reset mid-XFER → next cycle busy=0, core_rst=1, out_valid=0; new session with KEY_LEN=16, frame_len=4 completes normally.
- KEY_LEN=16, key 0x00..0x0F, init after 300 cycles, frame_len=4, in_data 0x41,0x42,0x43,0x44, core_ks 0x10,0x20,0x30,0x40 → out_data 0x51,0x62,0x73,0x04; done pulse once; 16 core_key_valid strobes.
- Same as above, but out_ready held 0 for 10 cycles after first output → out_data 0x51 stable, in_ready=0, no extra core_ks_req; stream resumes correctly.
- start with frame_len=0 → error=1, done pulse, core_rst stays 1, no key_ready.
- core_init_done never asserted, INIT_TIMEOUT=1024 → error=1 and done exactly 1024 cycles after WAIT_INIT entry; start pulses while busy ignored.
- RC4_DROP_EN, DROP_N=4, frame_len=1 → 5 core_ks_req total; output uses the 5th keystream byte; in_ready=0 during drop.

Source files
------------

// File: rtl/rc4_session_ctrl.sv
// rc4_session_ctrl: RC4 session sequencer (key load, init wait, keystream XOR stream); optional RC4_DROP_EN keystream drop
module rc4_session_ctrl #(
  parameter int KEY_LEN = 16,
  parameter int FRAME_LEN_W = 16,
  parameter int INIT_TIMEOUT = 1024,
  parameter int DROP_N = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  input  logic [7:0]             key_byte,
  input  logic                   key_valid,
  output logic                   key_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   core_rst,
  output logic [7:0]             core_key,
  output logic                   core_key_valid,
  input  logic                   core_init_done,
  output logic                   core_ks_req,
  input  logic [7:0]             core_ks,
  input  logic                   core_ks_valid
);
  localparam int KW = $clog2(KEY_LEN + 1);
  localparam int TW = $clog2(INIT_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD_KEY, WAIT_INIT, DROP, FETCH, WAIT_KS, XFER, DRAIN} state_t;
  state_t state_q, state_d;
  logic [FRAME_LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [KW-1:0] key_cnt_q, key_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] ks_q, ks_d, out_data_q, out_data_d, core_key_q, core_key_d;
  logic out_valid_q, out_valid_d, core_key_valid_q, core_key_valid_d;
  logic done_q, done_d, error_q, error_d;
`ifdef RC4_DROP_EN
  localparam int DW = $clog2(DROP_N + 1);
  logic [DW-1:0] drop_cnt_q, drop_cnt_d;
  logic drop_wait_q, drop_wait_d;
  assign core_ks_req = state_q == FETCH || (state_q == DROP && !drop_wait_q);
`else
  assign core_ks_req = state_q == FETCH;
`endif
  assign busy = state_q != IDLE;
  assign core_rst = state_q == IDLE;
  assign key_ready = state_q == LOAD_KEY;
  assign in_ready = state_q == XFER && (!out_valid_q || out_ready);
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign core_key = core_key_q;
  assign core_key_valid = core_key_valid_q;
  assign done = done_q;
  assign error = error_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    key_cnt_d = key_cnt_q;
    tmo_d = tmo_q;
    ks_d = ks_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    core_key_d = core_key_q;
    core_key_valid_d = 1'b0;
    done_d = 1'b0;
    error_d = error_q;
`ifdef RC4_DROP_EN
    drop_cnt_d = drop_cnt_q;
    drop_wait_d = drop_wait_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        len_d = frame_len;
        cnt_d = '0;
        key_cnt_d = '0;
        error_d = frame_len == '0;
        done_d = frame_len == '0;
        state_d = frame_len == '0 ? IDLE : LOAD_KEY;
      end
      LOAD_KEY: if (key_valid) begin
        core_key_d = key_byte;
        core_key_valid_d = 1'b1;
        key_cnt_d = key_cnt_q + KW'(1);
        if (key_cnt_q == KW'(KEY_LEN - 1)) begin
          state_d = WAIT_INIT;
          tmo_d = '0;
        end
      end
      WAIT_INIT: begin
        tmo_d = tmo_q + TW'(1);
        if (core_init_done) begin
`ifdef RC4_DROP_EN
          state_d = DROP;
          drop_cnt_d = '0;
          drop_wait_d = 1'b0;
`else
          state_d = FETCH;
`endif
        end else if (tmo_q == TW'(INIT_TIMEOUT - 1)) begin
          error_d = 1'b1;
          done_d = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef RC4_DROP_EN
      DROP: if (!drop_wait_q) drop_wait_d = 1'b1;
      else if (core_ks_valid) begin
        drop_wait_d = 1'b0;
        drop_cnt_d = drop_cnt_q + DW'(1);
        if (drop_cnt_q == DW'(DROP_N - 1)) begin
          drop_cnt_d = '0;
          state_d = FETCH;
        end
      end
`endif
      FETCH: state_d = WAIT_KS;
      WAIT_KS: if (core_ks_valid) begin
        ks_d = core_ks;
        state_d = XFER;
      end
      XFER: if (in_valid && in_ready) begin
        out_data_d = in_data ^ ks_q;
        out_valid_d = 1'b1;
        cnt_d = cnt_q + FRAME_LEN_W'(1);
        state_d = cnt_q == len_q - FRAME_LEN_W'(1) ? DRAIN : FETCH;
      end
      DRAIN: if (!out_valid_q) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      key_cnt_q <= '0;
      tmo_q <= '0;
      ks_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      core_key_q <= '0;
      core_key_valid_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt_q <= '0;
      drop_wait_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      key_cnt_q <= key_cnt_d;
      tmo_q <= tmo_d;
      ks_q <= ks_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      core_key_q <= core_key_d;
      core_key_valid_q <= core_key_valid_d;
      done_q <= done_d;
      error_q <= error_d;
`ifdef RC4_DROP_EN
      drop_cnt_q <= drop_cnt_d;
      drop_wait_q <= drop_wait_d;
`endif
    end
  end
endmodule

// File: tb/tb_rc4_session_ctrl.sv
// tb_rc4_session_ctrl: randomized self-checking bench for rc4_session_ctrl with a behavioural core and stream model
module tb_rc4_session_ctrl;
  localparam int KEY_LEN = 16;
  localparam int FW = 16;
  localparam int TMO = 1024;
`ifdef RC4_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif
  logic clk = 0, rst = 1, start = 0, key_valid = 0, in_valid = 0, out_ready = 0;
  logic core_init_done = 0, core_ks_valid = 0;
  logic [FW-1:0] frame_len = '0;
  logic [7:0] key_byte = 0, in_data = 0, core_ks = 0;
  logic key_ready, in_ready, out_valid, busy, done, error, core_rst, core_key_valid, core_ks_req;
  logic [7:0] out_data, core_key;
  int checks = 0, errors = 0;
  logic [7:0] ks_mem [8192];
  int req_cnt = 0, ks_wait = -1, pend_idx = 0, init_delay = 0, init_cnt = 0;
  always #5 clk = ~clk;
  rc4_session_ctrl #(.KEY_LEN(KEY_LEN), .FRAME_LEN_W(FW), .INIT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .key_byte(key_byte), .key_valid(key_valid), .key_ready(key_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error), .core_rst(core_rst),
    .core_key(core_key), .core_key_valid(core_key_valid), .core_init_done(core_init_done),
    .core_ks_req(core_ks_req), .core_ks(core_ks), .core_ks_valid(core_ks_valid)
  );
  always @(negedge clk) begin
    core_ks_valid = 0;
    if (ks_wait > 0) ks_wait--;
    if (ks_wait == 0) begin
      core_ks_valid = 1;
      core_ks = ks_mem[pend_idx % 8192];
      ks_wait = -1;
    end
    if (core_ks_req) begin
      pend_idx = req_cnt;
      req_cnt++;
      ks_wait = $urandom_range(1, 3);
    end
  end
  always @(negedge clk) begin
    if (core_rst) begin
      init_cnt = 0;
      core_init_done = 0;
    end else if (init_cnt >= init_delay) core_init_done = 1;
    else init_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic session(input int len, input int idelay, input bit directed, input bit stall, input bit abort);
    logic [7:0] keys [$];
    logic [7:0] data [$];
    logic [7:0] hold_d = 0;
    int base, nkey = 0, kidx = 0, nin = 0, nout = 0, stall_left = 10, cyc = 0;
    bit hold = 0, stalling;
    for (int i = 0; i < KEY_LEN; i++) keys.push_back(directed ? 8'(i) : 8'($urandom));
    for (int i = 0; i < len; i++) data.push_back(directed ? 8'(8'h41 + i) : 8'($urandom));
    base = req_cnt;
    if (directed) for (int i = 0; i < len; i++) ks_mem[(base + DROP + i) % 8192] = 8'(8'h10 * (i + 1));
    init_delay = idelay;
    @(negedge clk);
    frame_len = FW'(len);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("core_rst_released", core_rst, 0);
    while (cyc < 20000) begin
      if (core_key_valid) begin
        if (nkey < KEY_LEN) chk("core_key", core_key, keys[nkey]);
        nkey++;
      end
      if (hold) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, hold_d);
      end
      if (done) break;
      if (abort && nout >= 1) begin
        key_valid = 0;
        in_valid = 0;
        return;
      end
      key_valid = $urandom_range(0, 3) != 0;
      key_byte = kidx < KEY_LEN ? keys[kidx] : 8'h00;
      in_valid = nin < len && $urandom_range(0, 3) != 0;
      in_data = nin < len ? data[nin] : 8'h00;
      stalling = stall && nout == 0 && out_valid && stall_left > 0;
      out_ready = stalling ? 1'b0 : ($urandom_range(0, 4) != 0);
      #1;
      if (stalling) begin
        stall_left--;
        chk("stall_data", out_data, data[0] ^ ks_mem[(base + DROP) % 8192]);
        chk("stall_in_ready", in_ready, 0);
      end
      if (key_valid && key_ready) kidx++;
      if (in_valid && in_ready) nin++;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, data[nout] ^ ks_mem[(base + DROP + nout) % 8192]);
        nout++;
      end
      hold = out_valid && !out_ready;
      hold_d = out_data;
      @(negedge clk);
      cyc++;
    end
    key_valid = 0;
    in_valid = 0;
    chk("done_seen", done, 1);
    chk("bytes_out", nout, len);
    chk("key_strobes", nkey, KEY_LEN);
    chk("key_handshakes", kidx, KEY_LEN);
    chk("ks_requests", req_cnt - base, len + DROP);
    chk("error_end", error, 0);
    chk("busy_end", busy, 0);
    chk("core_rst_end", core_rst, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask
  initial begin
    int k, n;
    for (int i = 0; i < 8192; i++) ks_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ks_req", core_ks_req, 0);
    chk("rst_key_valid", core_key_valid, 0);
    rst = 0;
    session(4, 300, 1, 0, 0);
    session(4, 300, 1, 1, 0);
    @(negedge clk);
    frame_len = '0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("len0_done", done, 1);
    chk("len0_error", error, 1);
    chk("len0_busy", busy, 0);
    chk("len0_core_rst", core_rst, 1);
    chk("len0_key_ready", key_ready, 0);
    @(negedge clk);
    chk("len0_done_pulse", done, 0);
    chk("len0_error_sticky", error, 1);
    init_delay = 1000000;
    frame_len = FW'(3);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("tmo_error_cleared", error, 0);
    k = 0;
    key_valid = 1;
    for (int i = 0; i < 200 && k < KEY_LEN; i++) begin
      key_byte = 8'($urandom);
      #1;
      if (key_ready) k++;
      @(negedge clk);
    end
    key_valid = 0;
    chk("tmo_keys", k, KEY_LEN);
    n = 0;
    while (!done && n < 1100) begin
      start = n % 200 == 50;
      frame_len = '0;
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("tmo_cycles", n, TMO);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
    @(negedge clk);
    chk("tmo_done_pulse", done, 0);
    session(6, 10, 0, 0, 1);
    rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    chk("midrst_busy_next", busy, 0);
    chk("midrst_out_valid_next", out_valid, 0);
    rst = 0;
    session(4, 20, 0, 0, 0);
    session(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) session($urandom_range(1, 12), $urandom_range(0, 40), 0, i % 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
